// File: rtl/display_driver_pkg.sv
// Shared constants for the multiplexed 7-segment status display.
//   NUM_DIGITS : number of scanned digit positions (8, two hex digits per value)
//   SCAN_W     : width of the scan counter / digit index
//   SEG_TABLE  : hex nibble -> segment pattern, bits 6..0 = g,f,e,d,c,b,a
//   SEG_BLANK  : all segments off
//   DP_BIT     : bit position of the decimal point in a segment pattern
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SCAN_W     = $clog2(NUM_DIGITS);
  localparam int DP_BIT     = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high segments, dp clear in every entry.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,
    8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C,
    8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/display_driver_if.sv
// Bundle of the display data path between the controller logic and the driver.
//   clk_1hz         : slow page tick (asynchronous data, not a clock)
//   c9_11..c9_22    : page-0 byte values
//   c4_11..c4_22    : page-1 byte values
//   digit           : currently driven digit position
//   seg_data        : active-high segment pattern for digit (bit 7 = dp)
// master modport = the side supplying values; slave modport = the driver.
interface display_driver_if;
  import display_pkg::*;

  logic              clk_1hz;
  logic [7:0]        c9_11, c9_12, c9_21, c9_22;
  logic [7:0]        c4_11, c4_12, c4_21, c4_22;
  logic [SCAN_W-1:0] digit;
  logic [7:0]        seg_data;

  modport master (
    output clk_1hz,
    output c9_11, c9_12, c9_21, c9_22,
    output c4_11, c4_12, c4_21, c4_22,
    input  digit, seg_data
  );

  modport slave (
    input  clk_1hz,
    input  c9_11, c9_12, c9_21, c9_22,
    input  c4_11, c4_12, c4_21, c4_22,
    output digit, seg_data
  );

endinterface

// File: rtl/display_driver_hex_to_seg.sv
// Combinational hex nibble to 7-segment pattern decoder.
//   nibble : 4-bit value to display
//   seg    : active-high pattern, bits 6..0 = g..a, bit 7 (dp) always 0
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg         = SEG_TABLE[nibble];
    seg[DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/display_driver.sv
// Eight-position multiplexed 7-segment driver showing two pages of four bytes.
//   clk_1000hz : scan clock, one digit position per cycle
//   resetn     : synchronous active-low reset
//   bus        : display_driver_if slave (tick, page values, digit/segment outputs)
// The 1 Hz tick is synchronized, rising-edge detected and used to flip the
// page. Values are read live at each digit update, never latched.
module display_driver
  import display_pkg::*;
(
  input  logic              clk_1000hz,
  input  logic              resetn,
  display_driver_if.slave   bus
);

  logic [SCAN_W-1:0] scan;
  logic              page;
  logic              s1, s2, s3;

  logic [7:0] c9_vals [4];
  logic [7:0] c4_vals [4];
  logic [7:0] group   [4];
  logic [7:0] sel_byte;
  logic [3:0] nibble;
  logic [7:0] seg;
  logic       tick_rise;

  assign c9_vals[0] = bus.c9_11;
  assign c9_vals[1] = bus.c9_12;
  assign c9_vals[2] = bus.c9_21;
  assign c9_vals[3] = bus.c9_22;
  assign c4_vals[0] = bus.c4_11;
  assign c4_vals[1] = bus.c4_12;
  assign c4_vals[2] = bus.c4_21;
  assign c4_vals[3] = bus.c4_22;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_group
      assign group[gi] = page ? c4_vals[gi] : c9_vals[gi];
    end
  endgenerate

  // Two digit positions per byte: even index = high nibble, odd = low nibble.
  assign sel_byte = group[scan[SCAN_W-1:1]];
  assign nibble   = scan[0] ? sel_byte[3:0] : sel_byte[7:4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg)
  );

  // s3 clears on reset, so a tick already high at release is seen as a rise.
  assign tick_rise = s2 & ~s3;

  always_ff @(posedge clk_1000hz) begin
    if (!resetn) begin
      scan         <= '0;
      page         <= 1'b0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      bus.digit    <= '0;
      bus.seg_data <= SEG_BLANK;
    end else begin
      s1 <= bus.clk_1hz;
      s2 <= s1;
      s3 <= s2;
      if (tick_rise) begin
        page <= ~page;
      end
      // digit and seg_data are loaded together from the same scan value.
      bus.digit    <= scan;
      bus.seg_data <= seg;
      scan         <= scan + SCAN_W'(1);
    end
  end

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench for display_driver: a behavioural model derived from the
// page/scan rules is compared against the outputs every cycle, plus literal
// checks of the expected scan patterns.
module tb_display_driver;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  display_driver_if bus ();

  display_driver dut (
    .clk_1000hz (clk),
    .resetn     (resetn),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] pg0 [8] = '{8'h3F, 8'h06, 8'h3F, 8'h5B, 8'h3F, 8'h66, 8'h3F, 8'h7F};
  logic [7:0] pg1 [8] = '{8'h06, 8'h3F, 8'h5B, 8'h3F, 8'h66, 8'h3F, 8'h7F, 8'h3F};

  // ---------------- behavioural model ----------------
  int   n;            // non-reset edges since reset
  bit   hist [$];     // clk_1hz value seen at each non-reset edge
  bit   m_page;
  int   exp_digit;
  int   exp_seg;
  bit   model_valid = 0;

  function automatic bit samp(int k);
    if (k < 0 || k >= hist.size()) return 1'b0;
    return hist[k];
  endfunction

  always @(posedge clk) begin
    logic [7:0] vals [4];
    int idx, nib;
    if (!resetn) begin
      n = 0; hist.delete(); m_page = 0; exp_digit = 0; exp_seg = 0;
    end else begin
      if (m_page) vals = '{bus.c4_11, bus.c4_12, bus.c4_21, bus.c4_22};
      else        vals = '{bus.c9_11, bus.c9_12, bus.c9_21, bus.c9_22};
      idx = n % 8;
      nib = (idx % 2 == 0) ? (vals[idx / 2] / 16) : (vals[idx / 2] % 16);
      exp_digit = idx;
      exp_seg   = tbl[nib];
      hist.push_back(bus.clk_1hz);
      // A tick seen high at edge k after low at k-1 flips the page at edge k+2.
      if (samp(n - 2) && !samp(n - 3)) m_page = ~m_page;
      n++;
    end
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      total++;
      if (bus.digit !== 3'(exp_digit) || bus.seg_data !== 8'(exp_seg)) begin
        bad++;
        $display("FAIL model: digit=%0d seg=%02h required digit=%0d seg=%02h",
                 bus.digit, bus.seg_data, exp_digit, exp_seg);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  task automatic wait_digit(input int d);
    int k = 0;
    while (bus.digit !== 3'(d) && k < 20) begin
      @(negedge clk); k++;
    end
    if (k >= 20) begin
      total++; bad++;
      $display("FAIL wait_digit: digit=%0d required %0d (timeout)", bus.digit, d);
    end
  endtask

  task automatic check_scan(input string name, input logic [7:0] lit [8]);
    wait_digit(0);
    for (int i = 0; i < 8; i++) begin
      check({name, "_digit"}, 8'(bus.digit), 8'(i));
      check({name, "_seg"}, bus.seg_data, lit[i]);
      @(negedge clk);
    end
    $display("scan %s checked", name);
  endtask

  task automatic clocks(input int c);
    repeat (c) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    bus.clk_1hz = 1'b0;
    {bus.c9_11, bus.c9_12, bus.c9_21, bus.c9_22} = {8'h01, 8'h02, 8'h04, 8'h08};
    {bus.c4_11, bus.c4_12, bus.c4_21, bus.c4_22} = {8'h10, 8'h20, 8'h40, 8'h80};

    // reset held for 3 clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_digit", 8'(bus.digit), 8'h00);
      check("reset_seg", bus.seg_data, 8'h00);
    end
    $display("reset hold checked");

    resetn = 1'b1;
    @(negedge clk);
    check("first_digit", 8'(bus.digit), 8'h00);
    check("first_seg", bus.seg_data, 8'h3F);
    check_scan("page0", pg0);
    check_scan("page0_repeat", pg0);

    // mid-scan reset pulse
    wait_digit(5);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset_digit", 8'(bus.digit), 8'h00);
    check("midreset_seg", bus.seg_data, 8'h00);
    resetn = 1'b1;
    $display("mid-scan reset checked");

    // first tick rise -> page 1
    bus.clk_1hz = 1'b1;
    clocks(4);
    check_scan("page1", pg1);
    // fall alone has no effect
    bus.clk_1hz = 1'b0;
    clocks(10);
    check_scan("page1_after_fall", pg1);
    // second rise -> page 0, then held high for 50 clocks: only one toggle
    bus.clk_1hz = 1'b1;
    clocks(50);
    check_scan("page0_held_high", pg0);
    bus.clk_1hz = 1'b0;
    clocks(5);

    // live update while digit 3 is shown
    wait_digit(3);
    bus.c9_22 = 8'hA5;
    wait_digit(6);
    check("live_digit6", bus.seg_data, 8'h77);
    @(negedge clk);
    check("live_digit7", bus.seg_data, 8'h6D);
    $display("live update checked");

    // randomized tick and value traffic, checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.clk_1hz = ~bus.clk_1hz;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 7))
          0: bus.c9_11 = 8'($urandom); 1: bus.c9_12 = 8'($urandom);
          2: bus.c9_21 = 8'($urandom); 3: bus.c9_22 = 8'($urandom);
          4: bus.c4_11 = 8'($urandom); 5: bus.c4_12 = 8'($urandom);
          6: bus.c4_21 = 8'($urandom); default: bus.c4_22 = 8'($urandom);
        endcase
      end
    end
    $display("random phase done");

    // full decode sweep on page 0 (reset forces page 0, tick held low)
    bus.clk_1hz = 1'b0;
    resetn = 1'b0;
    clocks(2);
    resetn = 1'b1;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vb;
      vb = 8'(v);
      wait_digit(7);
      bus.c9_11 = vb;
      wait_digit(0);
      check("sweep_hi", bus.seg_data, tbl[vb[7:4]]);
      @(negedge clk);
      check("sweep_lo", bus.seg_data, tbl[vb[3:0]]);
    end
    $display("decode sweep done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
